// File: rtl/slc3_mem_arbiter_if.sv
// Bus bundle between the SLC-3 requesters (CPU, loader), the on-chip memory and the board I/O.
// The master side is the environment; the slave side is the arbiter.
interface slc3_mem_arbiter_if #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 16
);
  logic              cpu_req;
  logic              cpu_we;
  logic [ADDR_W-1:0] cpu_addr;
  logic [DATA_W-1:0] cpu_wdata;
  logic [DATA_W-1:0] cpu_rdata;
  logic              cpu_ack;

  logic              ld_req;
  logic              ld_we;
  logic [ADDR_W-1:0] ld_addr;
  logic [DATA_W-1:0] ld_wdata;
  logic [DATA_W-1:0] ld_rdata;
  logic              ld_ack;

  logic              mem_ce_n;
  logic              mem_oe_n;
  logic              mem_we_n;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;

  logic [9:0]        SW;
  logic [15:0]       hex_data;
  logic              busy;

  modport master (
    output cpu_req, cpu_we, cpu_addr, cpu_wdata,
    input  cpu_rdata, cpu_ack,
    output ld_req, ld_we, ld_addr, ld_wdata,
    input  ld_rdata, ld_ack,
    input  mem_ce_n, mem_oe_n, mem_we_n, mem_addr, mem_wdata,
    output mem_rdata,
    output SW,
    input  hex_data, busy
  );

  modport slave (
    input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
    output cpu_rdata, cpu_ack,
    input  ld_req, ld_we, ld_addr, ld_wdata,
    output ld_rdata, ld_ack,
    output mem_ce_n, mem_oe_n, mem_we_n, mem_addr, mem_wdata,
    input  mem_rdata,
    input  SW,
    output hex_data, busy
  );
endinterface

// File: rtl/slc3_mem_arbiter.sv
// Round-robin CPU/loader memory sequencer with fixed wait states and a one-cycle ack.
// Define SLC3_MMIO_EN to decode MMIO_ADDR as the switch (read) / HEX (write) I/O word.
module slc3_mem_arbiter #(
  parameter int                ADDR_W      = 16,
  parameter int                DATA_W      = 16,
  parameter int                WAIT_CYCLES = 2,
  parameter logic [ADDR_W-1:0] MMIO_ADDR   = 16'hFFFF
) (
  input logic               Clk,
  input logic               Reset_n,
  slc3_mem_arbiter_if.slave bus
);
  localparam int         PORTS    = 2;
  localparam logic [3:0] LAST_CNT = 4'(WAIT_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

  state_t            state_reg, state_next;
  logic [3:0]        cnt_reg, cnt_next;
  logic              grant_reg, grant_next;
  logic              last_grant_reg, last_grant_next;
  logic              latch_req;
  logic              last_access;
  logic              winner;
  logic              we_reg;
  logic              mmio_reg;
  logic              mmio_hit;
  logic              mem_access;
  logic [ADDR_W-1:0] mem_addr_reg;
  logic [DATA_W-1:0] mem_wdata_reg;
  logic [DATA_W-1:0] capture_data;

  // Port 0 is the CPU, port 1 the loader; grant bits use the same encoding.
  logic [PORTS-1:0]  req_vec;
  logic [PORTS-1:0]  we_vec;
  logic [PORTS-1:0]  ack_vec;
  logic [ADDR_W-1:0] addr_vec  [PORTS];
  logic [DATA_W-1:0] wdata_vec [PORTS];

  assign req_vec      = {bus.ld_req, bus.cpu_req};
  assign we_vec       = {bus.ld_we, bus.cpu_we};
  assign addr_vec[0]  = bus.cpu_addr;
  assign addr_vec[1]  = bus.ld_addr;
  assign wdata_vec[0] = bus.cpu_wdata;
  assign wdata_vec[1] = bus.ld_wdata;

  // On a tie the port that was not served last wins; otherwise the lone requester.
  assign winner = (req_vec == 2'b11) ? ~last_grant_reg : req_vec[1];

  always_ff @(posedge Clk) begin
    if (!Reset_n) begin
      state_reg      <= IDLE;
      cnt_reg        <= '0;
      grant_reg      <= 1'b0;
      last_grant_reg <= 1'b0;
    end else begin
      state_reg      <= state_next;
      cnt_reg        <= cnt_next;
      grant_reg      <= grant_next;
      last_grant_reg <= last_grant_next;
    end
  end

  always_comb begin
    state_next      = state_reg;
    cnt_next        = cnt_reg;
    grant_next      = grant_reg;
    last_grant_next = last_grant_reg;
    latch_req       = 1'b0;
    last_access     = 1'b0;
    unique case (state_reg)
      IDLE: begin
        if (|req_vec) begin
          latch_req       = 1'b1;
          grant_next      = winner;
          last_grant_next = winner;
          cnt_next        = '0;
          state_next      = ACCESS;
        end
      end
      ACCESS: begin
        if (cnt_reg == LAST_CNT) begin
          last_access = 1'b1;
          state_next  = DONE;
        end else begin
          cnt_next = cnt_reg + 4'd1;
        end
      end
      DONE: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  always_ff @(posedge Clk) begin
    if (!Reset_n) begin
      we_reg        <= 1'b0;
      mmio_reg      <= 1'b0;
      mem_addr_reg  <= '0;
      mem_wdata_reg <= '0;
    end else if (latch_req) begin
      we_reg        <= we_vec[winner];
      mmio_reg      <= mmio_hit;
      mem_addr_reg  <= addr_vec[winner];
      mem_wdata_reg <= wdata_vec[winner];
    end
  end

`ifdef SLC3_MMIO_EN
  logic [15:0]       hex_data_reg;
  logic [DATA_W-1:0] sw_word;

  assign mmio_hit = (addr_vec[winner] == MMIO_ADDR);

  always_comb begin
    sw_word      = '0;
    sw_word[9:0] = bus.SW;
  end

  assign capture_data = mmio_reg ? sw_word : bus.mem_rdata;

  always_ff @(posedge Clk) begin
    if (!Reset_n) begin
      hex_data_reg <= '0;
    end else if (last_access && we_reg && mmio_reg) begin
      hex_data_reg <= mem_wdata_reg[15:0];
    end
  end

  assign bus.hex_data = hex_data_reg;
`else
  logic unused_mmio;

  assign unused_mmio  = ^{bus.SW, MMIO_ADDR};
  assign mmio_hit     = 1'b0;
  assign capture_data = bus.mem_rdata;
  assign bus.hex_data = '0;
`endif

  // Each port keeps its own read-data register so a read result survives
  // traffic from the other port and its own writes.
  for (genvar gi = 0; gi < PORTS; gi++) begin : g_port
    logic [DATA_W-1:0] rdata_reg;

    always_ff @(posedge Clk) begin
      if (!Reset_n) begin
        rdata_reg <= '0;
      end else if (last_access && !we_reg && (grant_reg == 1'(gi))) begin
        rdata_reg <= capture_data;
      end
    end

    assign ack_vec[gi] = (state_reg == DONE) && (grant_reg == 1'(gi));
  end

  assign bus.cpu_rdata = g_port[0].rdata_reg;
  assign bus.ld_rdata  = g_port[1].rdata_reg;
  assign bus.cpu_ack   = ack_vec[0];
  assign bus.ld_ack    = ack_vec[1];

  assign mem_access    = (state_reg == ACCESS) && !mmio_reg;
  assign bus.mem_ce_n  = ~mem_access;
  assign bus.mem_oe_n  = ~(mem_access && !we_reg);
  assign bus.mem_we_n  = ~(mem_access && we_reg);
  assign bus.mem_addr  = mem_addr_reg;
  assign bus.mem_wdata = mem_wdata_reg;
  assign bus.busy      = (state_reg != IDLE);

endmodule

// File: tb/tb_slc3_mem_arbiter.sv
// Self-checking bench for slc3_mem_arbiter: echoing memory model, per-port expected-data queues.
// Checks follow SLC3_MMIO_EN when the bench is built with it.
module tb_slc3_mem_arbiter;
  localparam int WAIT = 2;
`ifdef SLC3_MMIO_EN
  localparam bit MMIO_ON = 1'b1;
`else
  localparam bit MMIO_ON = 1'b0;
`endif

  logic Clk = 1'b0;
  logic Reset_n = 1'b0;

  slc3_mem_arbiter_if #(.ADDR_W(16), .DATA_W(16)) bus ();

  slc3_mem_arbiter #(
    .ADDR_W(16), .DATA_W(16), .WAIT_CYCLES(WAIT), .MMIO_ADDR(16'hFFFF)
  ) dut (
    .Clk(Clk),
    .Reset_n(Reset_n),
    .bus(bus)
  );

  always #5 Clk = ~Clk;

  // Memory model: unwritten words read back as {a, ~a}.
  bit [15:0] mem_arr [256];
  bit        mem_vld [256];
  always @(posedge Clk) begin
    if (!bus.mem_ce_n && !bus.mem_we_n) begin
      mem_arr[bus.mem_addr[7:0]] <= bus.mem_wdata;
      mem_vld[bus.mem_addr[7:0]] <= 1'b1;
    end
  end
  assign bus.mem_rdata = mem_vld[bus.mem_addr[7:0]] ? mem_arr[bus.mem_addr[7:0]]
                                                    : {bus.mem_addr[7:0], ~bus.mem_addr[7:0]};

  int          errors = 0;
  int          checks = 0;
  bit          exp_last;
  logic [15:0] exp_cpu_rd, exp_ld_rd, exp_hex;
  logic [15:0] exp_mem [256];
  bit          exp_vld [256];
  logic [15:0] cpu_q [$];
  logic [15:0] ld_q  [$];

  function automatic logic [15:0] exp_read(input logic [15:0] a);
    logic [7:0] i;
    i = a[7:0];
    return exp_vld[i] ? exp_mem[i] : {i, ~i};
  endfunction

  task automatic clear_expect();
    exp_last   = 1'b0;
    exp_cpu_rd = '0;
    exp_ld_rd  = '0;
    exp_hex    = '0;
    cpu_q.delete();
    ld_q.delete();
  endtask

  task automatic apply_reset(input int cycles);
    bus.cpu_req = 1'b0;
    bus.ld_req  = 1'b0;
    @(negedge Clk);
    Reset_n = 1'b0;
    repeat (cycles) @(negedge Clk);
    Reset_n = 1'b1;
    clear_expect();
  endtask

  // Drive a request and, if push is set, record the rdata the port must show at its ack.
  task automatic start_req(input bit port, input bit we, input logic [15:0] addr,
                           input logic [15:0] wdata, input bit push);
    logic [15:0] rd;
    if (port == 1'b0) begin
      bus.cpu_req = 1'b1; bus.cpu_we = we; bus.cpu_addr = addr; bus.cpu_wdata = wdata;
    end else begin
      bus.ld_req = 1'b1; bus.ld_we = we; bus.ld_addr = addr; bus.ld_wdata = wdata;
    end
    if (push) begin
      if (we) begin
        if (MMIO_ON && addr == 16'hFFFF) exp_hex = wdata;
        else begin
          exp_mem[addr[7:0]] = wdata;
          exp_vld[addr[7:0]] = 1'b1;
        end
      end else begin
        rd = (MMIO_ON && addr == 16'hFFFF) ? {6'b0, bus.SW} : exp_read(addr);
        if (port == 1'b0) exp_cpu_rd = rd; else exp_ld_rd = rd;
      end
      if (port == 1'b0) cpu_q.push_back(exp_cpu_rd); else ld_q.push_back(exp_ld_rd);
    end
  endtask

  // Step negedges until an ack appears (lat=0 on timeout); drops req of acked ports.
  task automatic wait_ack(input int budget, output bit got_cpu, output bit got_ld,
                          output int lat, output int ce_low, output int oe_low, output int we_low);
    got_cpu = 1'b0; got_ld = 1'b0; lat = 0; ce_low = 0; oe_low = 0; we_low = 0;
    for (int i = 1; i <= budget; i++) begin
      @(negedge Clk);
      if (!bus.mem_ce_n) ce_low++;
      if (!bus.mem_oe_n) oe_low++;
      if (!bus.mem_we_n) we_low++;
      if (bus.cpu_ack || bus.ld_ack) begin
        got_cpu = bus.cpu_ack;
        got_ld  = bus.ld_ack;
        lat     = i;
        if (got_cpu) bus.cpu_req = 1'b0;
        if (got_ld)  bus.ld_req  = 1'b0;
        break;
      end
    end
  endtask

  task automatic test_reset();
    bit gc, gl; int lat, ce, oe, we; logic [15:0] e;
    bus.cpu_req = 1'b0; bus.cpu_we = 1'b0; bus.cpu_addr = '0; bus.cpu_wdata = '0;
    bus.ld_req = 1'b1; bus.ld_we = 1'b0; bus.ld_addr = 16'h0005; bus.ld_wdata = '0;
    bus.SW = '0;
    Reset_n = 1'b0;
    repeat (2) @(negedge Clk);
    checks++; if ({bus.mem_ce_n, bus.mem_oe_n, bus.mem_we_n} !== 3'b111) begin errors++; $display("FAIL reset_strobes: got %b want 111", {bus.mem_ce_n, bus.mem_oe_n, bus.mem_we_n}); end
    checks++; if ({bus.cpu_ack, bus.ld_ack, bus.busy} !== 3'b000) begin errors++; $display("FAIL reset_ack_busy: got %b want 000", {bus.cpu_ack, bus.ld_ack, bus.busy}); end
    checks++; if (bus.hex_data !== 16'h0000) begin errors++; $display("FAIL reset_hex: got %h want 0000", bus.hex_data); end
    checks++; if ({bus.mem_addr, bus.cpu_rdata, bus.ld_rdata} !== 48'h0) begin errors++; $display("FAIL reset_regs: got %h want 0", {bus.mem_addr, bus.cpu_rdata, bus.ld_rdata}); end
    Reset_n = 1'b1;
    clear_expect();
    start_req(1'b1, 1'b0, 16'h0005, 16'h0000, 1'b1);
    @(negedge Clk);
    checks++; if (bus.busy !== 1'b1 || bus.mem_addr !== 16'h0005) begin errors++; $display("FAIL reset_first_grant: got busy=%b addr=%h want busy=1 addr=0005", bus.busy, bus.mem_addr); end
    wait_ack(20, gc, gl, lat, ce, oe, we);
    checks++; if ({gc, gl} !== 2'b01 || lat != WAIT) begin errors++; $display("FAIL reset_ld_ack: got acks=%b lat=%0d want acks=01 lat=%0d", {gc, gl}, lat, WAIT); end
    e = ld_q.pop_front();
    checks++; if (bus.ld_rdata !== e) begin errors++; $display("FAIL reset_ld_rdata: got %h want %h", bus.ld_rdata, e); end
    $display("txn reset: loader read 0005 -> %h", bus.ld_rdata);
  endtask

  task automatic test_cpu_write_read();
    bit gc, gl; int lat, ce, oe, we; logic [15:0] e;
    @(negedge Clk);
    start_req(1'b0, 1'b1, 16'h0010, 16'hBEEF, 1'b1);
    wait_ack(20, gc, gl, lat, ce, oe, we);
    checks++; if ({gc, gl} !== 2'b10 || lat != WAIT + 1) begin errors++; $display("FAIL wr_ack: got acks=%b lat=%0d want acks=10 lat=%0d", {gc, gl}, lat, WAIT + 1); end
    checks++; if (we != WAIT || oe != 0 || ce != WAIT) begin errors++; $display("FAIL wr_strobes: got we=%0d oe=%0d ce=%0d want we=%0d oe=0 ce=%0d", we, oe, ce, WAIT, WAIT); end
    e = cpu_q.pop_front();
    checks++; if (bus.cpu_rdata !== e) begin errors++; $display("FAIL wr_rdata_hold: got %h want %h", bus.cpu_rdata, e); end
    $display("txn cpu write 0010 <= BEEF lat=%0d", lat);
    @(negedge Clk);
    checks++; if (bus.cpu_ack !== 1'b0) begin errors++; $display("FAIL ack_width: got %b want 0", bus.cpu_ack); end
    start_req(1'b0, 1'b0, 16'h0010, 16'h0000, 1'b1);
    wait_ack(20, gc, gl, lat, ce, oe, we);
    checks++; if ({gc, gl} !== 2'b10 || lat != WAIT + 1) begin errors++; $display("FAIL rd_ack: got acks=%b lat=%0d want acks=10 lat=%0d", {gc, gl}, lat, WAIT + 1); end
    checks++; if (oe != WAIT || we != 0) begin errors++; $display("FAIL rd_strobes: got oe=%0d we=%0d want oe=%0d we=0", oe, we, WAIT); end
    e = cpu_q.pop_front();
    checks++; if (bus.cpu_rdata !== e) begin errors++; $display("FAIL rd_data: got %h want %h", bus.cpu_rdata, e); end
    checks++; if (bus.ld_rdata !== exp_ld_rd) begin errors++; $display("FAIL rd_ld_hold: got %h want %h", bus.ld_rdata, exp_ld_rd); end
    exp_last = 1'b0;
    $display("txn cpu read 0010 -> %h", bus.cpu_rdata);
  endtask

  task automatic test_contention();
    bit gc, gl, first, exp_first; int lat, ce, oe, we; logic [15:0] e, obs;
    apply_reset(2);
    for (int r = 0; r < 3; r++) begin
      if (r == 2) begin
        start_req(1'b1, 1'b0, 16'h0050, 16'h0000, 1'b1);
        wait_ack(20, gc, gl, lat, ce, oe, we);
        e = ld_q.pop_front();
        checks++; if (!gl || bus.ld_rdata !== e) begin errors++; $display("FAIL solo_ld: got ack=%b data=%h want ack=1 data=%h", gl, bus.ld_rdata, e); end
        exp_last = 1'b1;
        @(negedge Clk);
      end
      exp_first = ~exp_last;
      start_req(1'b0, 1'b0, 16'h0020 + 16'(r), 16'h0000, 1'b1);
      start_req(1'b1, 1'b0, 16'h0040 + 16'(r), 16'h0000, 1'b1);
      wait_ack(20, gc, gl, lat, ce, oe, we);
      first = gl;
      checks++; if ((gc ^ gl) !== 1'b1 || first !== exp_first || lat != WAIT + 1) begin errors++; $display("FAIL tie%0d_first: got acks=%b lat=%0d want port=%0d lat=%0d", r, {gc, gl}, lat, exp_first, WAIT + 1); end
      e = first ? ld_q.pop_front() : cpu_q.pop_front();
      obs = first ? bus.ld_rdata : bus.cpu_rdata;
      checks++; if (obs !== e) begin errors++; $display("FAIL tie%0d_first_data: got %h want %h", r, obs, e); end
      exp_last = first;
      wait_ack(20, gc, gl, lat, ce, oe, we);
      checks++; if ({gc, gl} !== (first ? 2'b10 : 2'b01) || lat != WAIT + 2) begin errors++; $display("FAIL tie%0d_second: got acks=%b lat=%0d want port=%0d lat=%0d", r, {gc, gl}, lat, ~first, WAIT + 2); end
      e = first ? cpu_q.pop_front() : ld_q.pop_front();
      obs = first ? bus.cpu_rdata : bus.ld_rdata;
      checks++; if (obs !== e) begin errors++; $display("FAIL tie%0d_second_data: got %h want %h", r, obs, e); end
      exp_last = ~first;
      $display("txn tie %0d: first port=%0d second gap=%0d", r, first, lat);
      @(negedge Clk);
    end
  endtask

  task automatic test_abort();
    apply_reset(1);
    start_req(1'b0, 1'b1, 16'h0030, 16'h5555, 1'b0);
    repeat (2) @(negedge Clk);
    checks++; if (bus.mem_we_n !== 1'b0 || bus.busy !== 1'b1) begin errors++; $display("FAIL abort_pre: got we_n=%b busy=%b want 0 1", bus.mem_we_n, bus.busy); end
    Reset_n = 1'b0;
    @(negedge Clk);
    checks++; if ({bus.mem_ce_n, bus.mem_oe_n, bus.mem_we_n, bus.busy, bus.cpu_ack, bus.ld_ack} !== 6'b111000) begin errors++; $display("FAIL abort_post: got %b want 111000", {bus.mem_ce_n, bus.mem_oe_n, bus.mem_we_n, bus.busy, bus.cpu_ack, bus.ld_ack}); end
    bus.cpu_req = 1'b0;
    Reset_n = 1'b1;
    clear_expect();
    for (int i = 0; i < 4; i++) begin
      @(negedge Clk);
      checks++; if (bus.cpu_ack !== 1'b0 || bus.busy !== 1'b0) begin errors++; $display("FAIL abort_idle%0d: got ack=%b busy=%b want 0 0", i, bus.cpu_ack, bus.busy); end
    end
    $display("txn abort: write 0030 cancelled by reset");
  endtask

  task automatic test_mmio();
    bit gc, gl; int lat, ce, oe, we; logic [15:0] e;
    bus.SW = 10'd26;
    @(negedge Clk);
`ifdef SLC3_MMIO_EN
    start_req(1'b0, 1'b0, 16'hFFFF, 16'h0000, 1'b1);
    wait_ack(20, gc, gl, lat, ce, oe, we);
    e = cpu_q.pop_front();
    checks++; if (bus.cpu_rdata !== e || ce != 0 || lat != WAIT + 1) begin errors++; $display("FAIL mmio_rd: got data=%h ce=%0d lat=%0d want data=%h ce=0 lat=%0d", bus.cpu_rdata, ce, lat, e, WAIT + 1); end
    $display("txn mmio read FFFF -> %h", bus.cpu_rdata);
    @(negedge Clk);
    start_req(1'b0, 1'b1, 16'hFFFF, 16'h1234, 1'b1);
    wait_ack(20, gc, gl, lat, ce, oe, we);
    void'(cpu_q.pop_front());
    checks++; if (bus.hex_data !== exp_hex || ce != 0 || lat != WAIT + 1) begin errors++; $display("FAIL mmio_wr: got hex=%h ce=%0d lat=%0d want hex=%h ce=0 lat=%0d", bus.hex_data, ce, lat, exp_hex, WAIT + 1); end
    $display("txn mmio write FFFF <= 1234 hex=%h", bus.hex_data);
`else
    start_req(1'b0, 1'b1, 16'hFFFF, 16'h1234, 1'b1);
    wait_ack(20, gc, gl, lat, ce, oe, we);
    void'(cpu_q.pop_front());
    checks++; if (we != WAIT || bus.hex_data !== exp_hex) begin errors++; $display("FAIL plain_wr_ffff: got we=%0d hex=%h want we=%0d hex=%h", we, bus.hex_data, WAIT, exp_hex); end
    $display("txn write FFFF <= 1234 as memory");
    @(negedge Clk);
    start_req(1'b0, 1'b0, 16'hFFFF, 16'h0000, 1'b1);
    wait_ack(20, gc, gl, lat, ce, oe, we);
    e = cpu_q.pop_front();
    checks++; if (bus.cpu_rdata !== e || oe != WAIT) begin errors++; $display("FAIL plain_rd_ffff: got data=%h oe=%0d want data=%h oe=%0d", bus.cpu_rdata, oe, e, WAIT); end
    $display("txn read FFFF -> %h", bus.cpu_rdata);
`endif
  endtask

  task automatic test_back_to_back();
    bit gc, gl, wr; int lat, ce, oe, we; logic [15:0] a, d, e;
    @(negedge Clk);
    for (int i = 0; i < 6; i++) begin
      a  = 16'h0080 + 16'($urandom_range(0, 8'h0F));
      d  = 16'($urandom);
      wr = (i < 2) ? 1'b1 : 1'($urandom_range(0, 1));
      start_req(1'b1, wr, a, d, 1'b1);
      wait_ack(20, gc, gl, lat, ce, oe, we);
      e = ld_q.pop_front();
      checks++; if ({gc, gl} !== 2'b01 || lat != ((i == 0) ? WAIT + 1 : WAIT + 2)) begin errors++; $display("FAIL b2b%0d_timing: got acks=%b lat=%0d want acks=01 lat=%0d", i, {gc, gl}, lat, (i == 0) ? WAIT + 1 : WAIT + 2); end
      checks++; if (bus.ld_rdata !== e) begin errors++; $display("FAIL b2b%0d_data: got %h want %h", i, bus.ld_rdata, e); end
      $display("txn b2b %0d: loader %s %h data=%h rdata=%h lat=%0d", i, wr ? "write" : "read", a, d, bus.ld_rdata, lat);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_cpu_write_read();
    test_contention();
    test_abort();
    test_mmio();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
